// File: rtl/exec_alu_mc.sv
// exec_alu_mc: single-cycle ALU with result bypass and an iterative restoring
// divider for DIV/DIVU/REM/REMU.
module exec_alu_mc #(
  parameter int XLEN      = 32,
  parameter int FWD_DEPTH = 2,
  parameter int DIV_EN    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            flush,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  input  logic [4:0]      rs_no,
  input  logic [4:0]      rt_no,
  input  logic [4:0]      rd_in,
  output logic            done,
  output logic            busy,
  output logic [XLEN-1:0] data,
  output logic [4:0]      rd_out,
  output logic            wen
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_t;

  state_t          state, next_state;
  logic [4:0]      hist_rd   [FWD_DEPTH];
  logic [XLEN-1:0] hist_data [FWD_DEPTH];
  logic [XLEN-1:0] op_a, op_b, alu_res;
  logic [SHW-1:0]  shamt;
  logic            accept, is_div, div_signed, a_neg, b_neg;
  logic [XLEN-1:0] dv_quo, dv_rem, dv_div;
  logic            dv_neg_q, dv_neg_r, dv_zero, dv_want_rem;
  logic [4:0]      dv_rd;
  logic [SHW-1:0]  dv_cnt;
  logic [XLEN:0]   trial, diff;
  logic [XLEN-1:0] q_fin, r_fin;

  assign busy       = (state != S_IDLE);
  assign accept     = enable && (!busy || flush);
  assign is_div     = (DIV_EN != 0) && (alu_op[3:2] == 2'b11);
  assign div_signed = !alu_op[0];
  assign a_neg      = div_signed && op_a[XLEN-1];
  assign b_neg      = div_signed && op_b[XLEN-1];
  assign shamt      = op_b[SHW-1:0];

  // The live result is the newest entry: it is pushed into history on the same edge it is consumed.
  always_comb begin
    op_a = rs;
    op_b = rt;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (hist_rd[i] != 5'd0 && hist_rd[i] == rs_no) op_a = hist_data[i];
      if (hist_rd[i] != 5'd0 && hist_rd[i] == rt_no) op_b = hist_data[i];
    end
    if (wen && rd_out == rs_no) op_a = data;
    if (wen && rd_out == rt_no) op_b = data;
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = ~(op_a | op_b);
      4'd6:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd7:    alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'd8:    alu_res = op_a << shamt;
      4'd9:    alu_res = op_a >> shamt;
      4'd10:   alu_res = $signed(op_a) >>> shamt;
      4'd11:   alu_res = op_a * op_b;
      default: alu_res = op_a + op_b;
    endcase
  end

  // One restoring step; a borrow out of the top bit means the divisor did not fit.
  assign trial = {dv_rem, dv_quo[XLEN-1]};
  assign diff  = trial - {1'b0, dv_div};
  assign q_fin = dv_zero ? '1 : (dv_neg_q ? -dv_quo : dv_quo);
  assign r_fin = dv_neg_r ? -dv_rem : dv_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = S_IDLE;
      S_DIV:   if (dv_cnt == SHW'(XLEN - 1)) next_state = S_FIN;
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (flush) next_state = S_IDLE;
    if (accept && is_div) next_state = S_DIV;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done        <= 1'b0;
      wen         <= 1'b0;
      data        <= '0;
      rd_out      <= '0;
      dv_quo      <= '0;
      dv_rem      <= '0;
      dv_div      <= '0;
      dv_neg_q    <= 1'b0;
      dv_neg_r    <= 1'b0;
      dv_zero     <= 1'b0;
      dv_want_rem <= 1'b0;
      dv_rd       <= '0;
      dv_cnt      <= '0;
    end else begin
      done <= 1'b0;
      wen  <= 1'b0;
      if (accept && !is_div) begin
        data   <= alu_res;
        rd_out <= rd_in;
        done   <= 1'b1;
        wen    <= (rd_in != 5'd0);
      end else if (accept) begin
        dv_quo      <= a_neg ? -op_a : op_a;
        dv_rem      <= '0;
        dv_div      <= b_neg ? -op_b : op_b;
        dv_neg_q    <= a_neg ^ b_neg;
        dv_neg_r    <= a_neg;
        dv_zero     <= (op_b == '0);
        dv_want_rem <= alu_op[1];
        dv_rd       <= rd_in;
        dv_cnt      <= '0;
      end else if (state == S_DIV) begin
        dv_rem <= diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
        dv_quo <= {dv_quo[XLEN-2:0], !diff[XLEN]};
        dv_cnt <= dv_cnt + 1'b1;
      end else if (state == S_FIN && !flush) begin
        data   <= dv_want_rem ? r_fin : q_fin;
        rd_out <= dv_rd;
        done   <= 1'b1;
        wen    <= (dv_rd != 5'd0);
      end
    end
  end

  // History shifts only on write-back cycles; flush leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FWD_DEPTH; i++) begin
        hist_rd[i]   <= '0;
        hist_data[i] <= '0;
      end
    end else if (wen) begin
      hist_rd[0]   <= rd_out;
      hist_data[0] <= data;
      for (int i = 1; i < FWD_DEPTH; i++) begin
        hist_rd[i]   <= hist_rd[i-1];
        hist_data[i] <= hist_data[i-1];
      end
    end
  end

endmodule

// File: tb/tb_exec_alu_mc.sv
// Self-checking bench for exec_alu_mc: vector table through a result scoreboard,
// plus hand-written divide latency, busy, flush and reset sequences.
module tb_exec_alu_mc;

  localparam int XLEN = 32;
  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_NOR = 4'd5,  OP_SLT = 4'd6,  OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8,  OP_SRL = 4'd9,  OP_SRA = 4'd10, OP_MUL = 4'd11;
  localparam logic [3:0] OP_DIV = 4'd12, OP_DIVU = 4'd13, OP_REM = 4'd14, OP_REMU = 4'd15;

  typedef struct {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
    string           name;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    string           name;
  } exp_t;

  logic            clk, rst, enable, flush;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] rs, rt;
  logic [4:0]      rs_no, rt_no, rd_in;
  logic            done, busy, wen;
  logic [XLEN-1:0] data;
  logic [4:0]      rd_out;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   lat;

  exec_alu_mc #(.XLEN(XLEN), .FWD_DEPTH(2), .DIV_EN(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .alu_op(alu_op),
    .rs(rs), .rt(rt), .rs_no(rs_no), .rt_no(rt_no), .rd_in(rd_in),
    .done(done), .busy(busy), .data(data), .rd_out(rd_out), .wen(wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [4:0] rsn, input logic [4:0] rtn, input logic [4:0] rd,
                               input logic expect_result, input logic [XLEN-1:0] exp_data, input string nm);
    alu_op = op; rs = a; rt = b; rs_no = rsn; rt_no = rtn; rd_in = rd; enable = 1'b1;
    if (expect_result) exp_q.push_back('{exp_data, rd, nm});
    @(posedge clk);
    #1 enable = 1'b0;
  endtask

  task automatic waitDrain(input int max_cycles, input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: %0d results still outstanding, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: got done=1 data=%h rd=%0d, required no completion", data, rd_out);
      end else begin
        e = exp_q.pop_front();
        checkOutput({e.name, "_data"}, 64'(data), 64'(e.data));
        checkOutput({e.name, "_rd"}, 64'(rd_out), 64'(e.rd));
        checkOutput({e.name, "_wen"}, 64'(wen), 64'(e.rd != 5'd0));
      end
    end else if (!rst && wen) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL stray_wen: got wen=1 with done=0, required wen=0");
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; alu_op = '0;
    rs = '0; rt = '0; rs_no = '0; rt_no = '0; rd_in = '0;

    vecs.push_back('{OP_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0,         "add_wrap"});
    vecs.push_back('{OP_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, "sub_neg"});
    vecs.push_back('{OP_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, "and"});
    vecs.push_back('{OP_OR,   32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, "or"});
    vecs.push_back('{OP_XOR,  32'h0000_FF00, 32'h0000_0FF0, 32'h0000_F0F0, "xor"});
    vecs.push_back('{OP_NOR,  32'd0,         32'd0,         32'hFFFF_FFFF, "nor"});
    vecs.push_back('{OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         "slt_signed"});
    vecs.push_back('{OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         "sltu"});
    vecs.push_back('{OP_SLL,  32'd1,         32'h21,        32'd2,         "sll_mask"});
    vecs.push_back('{OP_SRL,  32'h8000_0000, 32'd31,        32'd1,         "srl"});
    vecs.push_back('{OP_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, "sra"});
    vecs.push_back('{OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'd0,         "mul_low"});
    vecs.push_back('{OP_MUL,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, "mul_neg"});
    vecs.push_back('{OP_DIVU, 32'd100,       32'd7,         32'd14,        "divu"});
    vecs.push_back('{OP_REMU, 32'd100,       32'd7,         32'd2,         "remu"});
    vecs.push_back('{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_neg"});
    vecs.push_back('{OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_neg"});
    vecs.push_back('{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_negdivisor"});
    vecs.push_back('{OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         "rem_negdivisor"});
    vecs.push_back('{OP_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF, "divu_zero"});
    vecs.push_back('{OP_REMU, 32'd9,         32'd0,         32'd9,         "remu_zero"});
    vecs.push_back('{OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, "div_zero"});
    vecs.push_back('{OP_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, "rem_zero"});
    vecs.push_back('{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"});
    vecs.push_back('{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf"});

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_data", 64'(data), 64'd0);
    checkOutput("reset_rd", 64'(rd_out), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_wen", 64'(wen), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single-cycle result and back-to-back bypass");
    applyStimulus(OP_ADD, 32'd5, 32'd7, 5'd0, 5'd0, 5'd3, 1'b1, 32'd12, "add_basic");
    checkOutput("add_done_after_1_edge", 64'(done), 64'd1);
    applyStimulus(OP_SUB, 32'd0, 32'd2, 5'd3, 5'd0, 5'd4, 1'b1, 32'd10, "sub_bypass");
    waitDrain(5, "bypass");

    applyStimulus(OP_ADD, 32'd50, 32'd0, 5'd0, 5'd0, 5'd5, 1'b1, 32'd50, "fwd_r5");
    applyStimulus(OP_ADD, 32'd99, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'd99, "rd0_result");
    applyStimulus(OP_ADD, 32'd1,  32'd3, 5'd5, 5'd0, 5'd8, 1'b1, 32'd53, "fwd_skip_rd0");
    applyStimulus(OP_ADD, 32'd10, 32'd0, 5'd0, 5'd0, 5'd6, 1'b1, 32'd10, "r6_old");
    applyStimulus(OP_ADD, 32'd20, 32'd0, 5'd0, 5'd0, 5'd6, 1'b1, 32'd20, "r6_new");
    applyStimulus(OP_OR,  32'd0,  32'd0, 5'd6, 5'd6, 5'd9, 1'b1, 32'd20, "fwd_newest");
    waitDrain(5, "history");

    $display("[TB] vector table");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 5'd0, 5'd0, 5'(i), 1'b1, vecs[i].res, vecs[i].name);
      waitDrain(50, vecs[i].name);
    end

    $display("[TB] divide latency");
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 5'd0, 5'd9, 1'b1, 32'hFFFF_FFFD, "div_lat");
    checkOutput("div_busy_at_accept", 64'(busy), 64'd1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    checkOutput("div_latency", 64'(lat), 64'd33);
    checkOutput("div_busy_after_fin", 64'(busy), 64'd0);
    waitDrain(5, "div_lat");

    $display("[TB] enable ignored while busy");
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd0, 5'd0, 5'd2, 1'b1, 32'd14, "divu_busy");
    alu_op = OP_ADD; rs = 32'd1; rt = 32'd1; rd_in = 5'd5; enable = 1'b1;
    repeat (5) @(posedge clk);
    #1 enable = 1'b0;
    checkOutput("busy_held", 64'(busy), 64'd1);
    waitDrain(40, "divu_busy");
    repeat (5) @(posedge clk);
    #1;

    $display("[TB] flush at iteration 10");
    applyStimulus(OP_DIV, 32'd1000, 32'd3, 5'd0, 5'd0, 5'd4, 1'b0, 32'd0, "div_flushed");
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checkOutput("flush_busy", 64'(busy), 64'd0);
    checkOutput("flush_done", 64'(done), 64'd0);
    repeat (40) @(posedge clk);
    #1;

    applyStimulus(OP_DIV, 32'd50, 32'd5, 5'd0, 5'd0, 5'd4, 1'b0, 32'd0, "div_flushed2");
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    applyStimulus(OP_ADD, 32'd2, 32'd3, 5'd0, 5'd0, 5'd7, 1'b1, 32'd5, "flush_accept");
    flush = 1'b0;
    checkOutput("flush_accept_busy", 64'(busy), 64'd0);
    waitDrain(5, "flush_accept");
    repeat (40) @(posedge clk);
    #1;

    $display("[TB] reset mid-divide");
    applyStimulus(OP_DIV, 32'd77, 32'd3, 5'd0, 5'd0, 5'd4, 1'b0, 32'd0, "div_reset");
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_data", 64'(data), 64'd0);
    checkOutput("async_rst_rd", 64'(rd_out), 64'd0);
    checkOutput("async_rst_busy", 64'(busy), 64'd0);
    checkOutput("async_rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    applyStimulus(OP_ADD, 32'd40, 32'd1, 5'd7, 5'd0, 5'd0, 1'b1, 32'd41, "hist_cleared");
    waitDrain(5, "hist_cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_alu_mc.md
EXEC_ALU_MC -- requirements
Module: exec_alu_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width in bits (legal 8..64).
REQ-002 SHALL have parameter FWD_DEPTH, default 2, meaning number of retained result entries usable for operand bypass (legal 1..4).
REQ-003 SHALL have parameter DIV_EN, default 1, meaning iterative divider present; when 0, divide ops execute as ADD.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port enable  input  1  issue strobe; the op is accepted on an edge where enable=1 and busy=0.
REQ-007 SHALL have port flush  input  1  aborts an in-flight divide.
REQ-008 SHALL have port alu_op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MUL, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
REQ-009 SHALL have ports rs, rt  input  XLEN each  register-file operands; rs_no, rt_no, rd_in  input  5 each  register numbers.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port busy  output  1  divider occupied; enable is ignored while high.
REQ-012 SHALL have ports data  output  XLEN  result; rd_out  output  5  destination; wen  output  1  write-back valid, high in the done cycle only when rd_out != 0.

Function
REQ-013 SHALL bypass: effective operand = data of the most recent history entry with wen=1, rd = rs_no/rt_no and rd != 0; otherwise the rs/rt port value.
REQ-014 SHALL push {rd_out, data} into the FWD_DEPTH-entry history on every edge where wen is asserted; the oldest entry is discarded.
REQ-015 SHALL complete ops 0..11 in one cycle: accept edge N -> data, rd_out, done, wen valid after edge N, for one cycle.
REQ-016 SHALL use rt[log2(XLEN)-1:0] as the shift amount; SRA sign-fills; SLT is signed and SLTU unsigned, result 0 or 1.
REQ-017 SHALL return the low XLEN bits of the product for MUL.
REQ-018 SHALL implement DIV/DIVU/REM/REMU with an FSM IDLE -> DIV (XLEN restoring radix-2 iterations on |operands|) -> FIN (sign fix-up, register result) -> IDLE.
REQ-019 SHALL make divide latency exactly XLEN+1 edges after the accept edge regardless of operands; busy high from the accept edge until the FIN edge.
REQ-020 SHALL, for divisor 0: quotient = all ones, remainder = dividend.
REQ-021 SHALL, for signed overflow (dividend = most negative, divisor = -1): quotient = dividend, remainder = 0.
REQ-022 SHALL give remainder the sign of the dividend and truncate quotient toward zero.
REQ-023 SHALL, on flush=1, return to IDLE on that edge, deassert busy, emit no done/wen, and keep history; flush with enable on the same edge accepts the new op.
REQ-024 SHALL deassert done and wen in every cycle not specified above; data and rd_out hold their last values.
REQ-025 SHALL latch operands at the accept edge so that later rs/rt changes do not affect an in-flight divide.

Reset
REQ-026 SHALL, while rst=1, force FSM=IDLE, busy=0, done=0, wen=0, data=0, rd_out=0, and clear all history entries to rd=0.
REQ-027 SHALL discard an in-flight divide on reset without a done pulse.

Verification
REQ-028 SHALL pass: ADD rs=5 rt=7 rd_in=3 -> after 1 edge data=12, rd_out=3, done=1, wen=1.
REQ-029 SHALL pass: back-to-back ADD r3=12 then SUB rs_no=3 (port rs=0) rt=2 -> data=10 via bypass; rd_in=0 results are never forwarded.
REQ-030 SHALL pass (XLEN=32): DIV -7/2 -> done exactly 33 edges after accept, data=-3; REM -7/2 -> data=-1.
REQ-031 SHALL pass: DIVU 9/0 -> data=0xFFFFFFFF; REMU 9/0 -> 9; DIV 0x80000000/-1 -> 0x80000000.
REQ-032 SHALL pass: enable during busy ignored (no second done); flush at iteration 10 -> busy=0 next cycle, no done.
REQ-033 SHALL pass: rst asserted mid-divide -> outputs zero immediately (asynchronous), no done after release.
